// File: rtl/dmaster_pkt_pkg.sv
// Framing symbols, escape rule and sequencer states shared by the
// debug-master packets-to-bytes path.
package dmaster_pkt_pkg;

    localparam logic [7:0] SYM_SOP  = 8'h7A;
    localparam logic [7:0] SYM_EOP  = 8'h7B;
    localparam logic [7:0] SYM_CHAN = 8'h7C;
    localparam logic [7:0] SYM_ESC  = 8'h7D;
    localparam logic [7:0] ESC_XOR  = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        CH_CHAR,
        CH_ESC,
        CH_BYTE,
        SOP_CHAR,
        EOP_CHAR,
        D_ESC,
        D_BYTE
    } p2b_state_t;

    function automatic logic needs_esc(input logic [7:0] b);
        return (b >= SYM_SOP) && (b <= SYM_ESC);
    endfunction

endpackage

// File: rtl/fpga_ddr3_example_if0_dmaster_p2b.sv
// Packets-to-bytes encoder: expands each accepted Avalon-ST beat into an
// in-band framed, escaped byte sequence for the byte PHY.
module fpga_ddr3_example_if0_dmaster_p2b
    import dmaster_pkt_pkg::*;
#(
    parameter int CHANNEL_WIDTH  = 8,
    parameter bit SEND_CH_ON_SOP = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic [CHANNEL_WIDTH-1:0] in_channel,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data
);

    p2b_state_t state;
    p2b_state_t entry_state;
    p2b_state_t data_state;

    logic [7:0] h_data;
    logic [7:0] h_ch;
    logic       h_sop;
    logic       h_eop;
    logic [7:0] last_ch;
    logic       last_ch_valid;
    logic [7:0] ch_ext;
    logic       hdr_due;
    logic       accept;

    assign in_ready  = (state == IDLE) || ((state == D_BYTE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state != IDLE);

    // Entry decision looks at the incoming beat; everything after uses held copies.
    always_comb begin
        ch_ext                      = '0;
        ch_ext[CHANNEL_WIDTH-1:0]   = in_channel;
        hdr_due = (in_startofpacket && SEND_CH_ON_SOP) || !last_ch_valid || (ch_ext != last_ch);
        if (hdr_due)
            entry_state = CH_CHAR;
        else if (in_startofpacket)
            entry_state = SOP_CHAR;
        else if (in_endofpacket)
            entry_state = EOP_CHAR;
        else if (needs_esc(in_data))
            entry_state = D_ESC;
        else
            entry_state = D_BYTE;
        data_state = needs_esc(h_data) ? D_ESC : D_BYTE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            h_data        <= '0;
            h_ch          <= '0;
            h_sop         <= 1'b0;
            h_eop         <= 1'b0;
            last_ch       <= '0;
            last_ch_valid <= 1'b0;
        end else begin
            if (accept) begin
                h_data <= in_data;
                h_ch   <= ch_ext;
                h_sop  <= in_startofpacket;
                h_eop  <= in_endofpacket;
            end
            if (state == IDLE) begin
                if (accept)
                    state <= entry_state;
            end else if (out_ready) begin
                case (state)
                    CH_CHAR:  state <= needs_esc(h_ch) ? CH_ESC : CH_BYTE;
                    CH_ESC:   state <= CH_BYTE;
                    CH_BYTE: begin
                        last_ch       <= h_ch;
                        last_ch_valid <= 1'b1;
                        if (h_sop)
                            state <= SOP_CHAR;
                        else if (h_eop)
                            state <= EOP_CHAR;
                        else
                            state <= data_state;
                    end
                    SOP_CHAR: state <= h_eop ? EOP_CHAR : data_state;
                    EOP_CHAR: state <= data_state;
                    D_ESC:    state <= D_BYTE;
                    D_BYTE:   state <= accept ? entry_state : IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (state)
            CH_CHAR:  out_data = SYM_CHAN;
            CH_ESC:   out_data = SYM_ESC;
            CH_BYTE:  out_data = needs_esc(h_ch) ? (h_ch ^ ESC_XOR) : h_ch;
            SOP_CHAR: out_data = SYM_SOP;
            EOP_CHAR: out_data = SYM_EOP;
            D_ESC:    out_data = SYM_ESC;
            D_BYTE:   out_data = needs_esc(h_data) ? (h_data ^ ESC_XOR) : h_data;
            default:  out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_fpga_ddr3_example_if0_dmaster_p2b.sv
// Bench for the packets-to-bytes encoder: lane 0 sends a header on every SOP,
// lane 1 only on channel change; each lane has a byte-queue reference model.
module tb_fpga_ddr3_example_if0_dmaster_p2b;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     [2];
    logic       in_valid  [2];
    logic [7:0] in_data   [2];
    logic       in_sop    [2];
    logic       in_eop    [2];
    logic [7:0] in_ch     [2];
    logic       out_ready [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic [7:0] out_data  [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rnd    = 1'b0;

    logic [7:0] cap   [2][$];
    int         cap_t [2][$];
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc++;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : lane
            fpga_ddr3_example_if0_dmaster_p2b #(
                .CHANNEL_WIDTH (8),
                .SEND_CH_ON_SOP(g == 0 ? 1'b1 : 1'b0)
            ) dut (
                .clk             (clk),
                .reset           (reset[g]),
                .in_ready        (in_ready[g]),
                .in_valid        (in_valid[g]),
                .in_data         (in_data[g]),
                .in_startofpacket(in_sop[g]),
                .in_endofpacket  (in_eop[g]),
                .in_channel      (in_ch[g]),
                .out_ready       (out_ready[g]),
                .out_valid       (out_valid[g]),
                .out_data        (out_data[g])
            );

            // Model: bytes still owed downstream, in order.
            logic [7:0] q [$];
            bit         lv    = 1'b0;
            logic [7:0] lch   = 8'h00;
            bit         armed = 1'b0;

            function automatic void enc(input logic [7:0] b);
                if (b >= 8'h7A && b <= 8'h7D) begin
                    q.push_back(8'h7D);
                    q.push_back(b ^ 8'h20);
                end else begin
                    q.push_back(b);
                end
            endfunction

            always @(negedge clk) begin : cmp
                bit exp_rdy;
                bit hdr;
                exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready[g]);
                if (armed) begin
                    checks++;
                    if (out_valid[g] !== (q.size() != 0)) begin
                        errors++;
                        $display("FAIL lane%0d out_valid got %b want %b (cyc %0d)", g, out_valid[g], q.size() != 0, cyc);
                    end
                    checks++;
                    if (out_data[g] !== ((q.size() != 0) ? q[0] : 8'h00)) begin
                        errors++;
                        $display("FAIL lane%0d out_data got %02h want %02h (cyc %0d)", g, out_data[g],
                                 (q.size() != 0) ? q[0] : 8'h00, cyc);
                    end
                    checks++;
                    if (in_ready[g] !== exp_rdy) begin
                        errors++;
                        $display("FAIL lane%0d in_ready got %b want %b (cyc %0d)", g, in_ready[g], exp_rdy, cyc);
                    end
                end
                if (reset[g]) begin
                    q.delete();
                    lv    = 1'b0;
                    armed = 1'b1;
                end else if (armed) begin
                    if (q.size() != 0 && out_ready[g]) begin
                        cap[g].push_back(q[0]);
                        cap_t[g].push_back(cyc);
                        void'(q.pop_front());
                    end
                    if (in_valid[g] && exp_rdy) begin
                        hdr = (in_sop[g] && g == 0) || !lv || (in_ch[g] != lch);
                        if (hdr) begin
                            q.push_back(8'h7C);
                            enc(in_ch[g]);
                            lv  = 1'b1;
                            lch = in_ch[g];
                        end
                        if (in_sop[g]) q.push_back(8'h7A);
                        if (in_eop[g]) q.push_back(8'h7B);
                        enc(in_data[g]);
                    end
                end
            end
        end
    endgenerate

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick(input int d);
        @(posedge clk);
        #1;
        if (rnd) out_ready[d] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input int d, input logic [7:0] data, input logic [7:0] ch,
                             input logic sop, input logic eop);
        bit acc;
        acc = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_ch[d]    = ch;
        in_sop[d]   = sop;
        in_eop[d]   = eop;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready[d];
            tick(d);
        end
        if (!acc) begin
            errors++;
            $display("FAIL lane%0d accept_timeout data %02h", d, data);
        end
    endtask

    task automatic drain(input int d);
        bit done;
        done = 1'b0;
        in_valid[d] = 1'b0;
        for (int n = 0; n < 600 && !done; n++) begin
            @(negedge clk);
            if (out_valid[d] === 1'b0) done = 1'b1;
            else tick(d);
        end
        if (done) tick(d);
        else begin
            errors++;
            $display("FAIL lane%0d drain_timeout", d);
        end
    endtask

    task automatic expect_cap(input int d, input string name);
        checks++;
        if (cap[d].size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s length got %0d want %0d", name, cap[d].size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap[d].size(); i++) begin
            checks++;
            if (cap[d][i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s byte%0d got %02h want %02h", name, i, cap[d][i], exp_q[i]);
            end
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        if ($urandom_range(0, 3) == 0) return 8'h7A + 8'($urandom_range(0, 3));
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d]     = 1'b1;
            in_valid[d]  = 1'b0;
            in_data[d]   = 8'h00;
            in_sop[d]    = 1'b0;
            in_eop[d]    = 1'b0;
            in_ch[d]     = 8'h00;
            out_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_int("reset_out_valid", int'(out_valid[d]), 0);
            check_int("reset_out_data", int'(out_data[d]), 0);
            check_int("reset_in_ready", int'(in_ready[d]), 1);
        end
        tick(0);

        // single-beat packet
        cap[0].delete(); cap_t[0].delete();
        send_beat(0, 8'h41, 8'h00, 1'b1, 1'b1);
        in_valid[0] = 1'b0;
        drain(0);
        exp_q = '{8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h41};
        expect_cap(0, "single_beat");
        if (cap_t[0].size() == 5) check_int("single_beat_span", cap_t[0][4] - cap_t[0][0], 4);

        // gap-free three-beat packet
        cap[0].delete(); cap_t[0].delete();
        send_beat(0, 8'h01, 8'h03, 1'b1, 1'b0);
        send_beat(0, 8'h02, 8'h03, 1'b0, 1'b0);
        send_beat(0, 8'h03, 8'h03, 1'b0, 1'b1);
        in_valid[0] = 1'b0;
        drain(0);
        exp_q = '{8'h7C, 8'h03, 8'h7A, 8'h01, 8'h02, 8'h7B, 8'h03};
        expect_cap(0, "three_beat");
        if (cap_t[0].size() == 7) check_int("three_beat_span", cap_t[0][6] - cap_t[0][0], 6);

        // payload escaping
        cap[0].delete();
        send_beat(0, 8'h7D, 8'h03, 1'b1, 1'b0);
        send_beat(0, 8'h7A, 8'h03, 1'b0, 1'b0);
        send_beat(0, 8'h79, 8'h03, 1'b0, 1'b1);
        drain(0);
        exp_q = '{8'h7C, 8'h03, 8'h7A, 8'h7D, 8'h5D, 8'h7D, 8'h5A, 8'h7B, 8'h79};
        expect_cap(0, "payload_escape");

        // escaped channel byte
        cap[0].delete();
        send_beat(0, 8'h00, 8'h7B, 1'b1, 1'b1);
        drain(0);
        exp_q = '{8'h7C, 8'h7D, 8'h5B, 8'h7A, 8'h7B, 8'h00};
        expect_cap(0, "chan_escape");

        // header only on channel change
        cap[1].delete();
        send_beat(1, 8'h11, 8'h7B, 1'b1, 1'b1);
        send_beat(1, 8'h22, 8'h7B, 1'b1, 1'b1);
        drain(1);
        exp_q = '{8'h7C, 8'h7D, 8'h5B, 8'h7A, 8'h7B, 8'h11, 8'h7A, 8'h7B, 8'h22};
        expect_cap(1, "no_repeat_header");

        // backpressure while the SOP marker is on the wire
        cap[0].delete();
        send_beat(0, 8'h10, 8'h03, 1'b1, 1'b0);
        in_valid[0] = 1'b0;
        tick(0);
        tick(0);
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_int("stall_out_data", int'(out_data[0]), 8'h7A);
            check_int("stall_in_ready", int'(in_ready[0]), 0);
            tick(0);
        end
        out_ready[0] = 1'b1;
        drain(0);
        exp_q = '{8'h7C, 8'h03, 8'h7A, 8'h10};
        expect_cap(0, "stall_sequence");

        // reset in the middle of a channel header
        send_beat(1, 8'h01, 8'h09, 1'b1, 1'b1);
        drain(1);
        send_beat(1, 8'h41, 8'h05, 1'b1, 1'b0);
        in_valid[1] = 1'b0;
        tick(1);
        out_ready[1] = 1'b0;
        @(negedge clk);
        check_int("pre_reset_ch_byte", int'(out_data[1]), 8'h05);
        tick(1);
        reset[1] = 1'b1;
        tick(1);
        reset[1] = 1'b0;
        @(negedge clk);
        check_int("post_reset_out_valid", int'(out_valid[1]), 0);
        tick(1);
        out_ready[1] = 1'b1;
        cap[1].delete();
        send_beat(1, 8'h41, 8'h09, 1'b0, 1'b0);
        drain(1);
        exp_q = '{8'h7C, 8'h09, 8'h41};
        expect_cap(1, "post_reset_header");

        // randomized traffic with backpressure and occasional resets
        rnd = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 49) == 0) begin
                    in_valid[d] = 1'b0;
                    reset[d] = 1'b1;
                    tick(d);
                    reset[d] = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) begin
                    in_valid[d] = 1'b0;
                    repeat ($urandom_range(1, 3)) tick(d);
                end
                send_beat(d, rnd_byte(),
                          ($urandom_range(0, 5) == 0) ? 8'h7C + 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            drain(d);
        end
        rnd = 1'b0;
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
